ro_entropy_collector: RTL and testbench



---
 rtl/trng_pkg.sv | 22 ++
 rtl/vn_debiaser.sv | 34 +++
 rtl/ro_entropy_collector.sv | 141 ++++++++++++++
 tb/tb_ro_entropy_collector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared definitions for the ring-oscillator entropy collector.
// Holds the collector state encoding, default sizes and counter width helper.
package trng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WARMUP  = 3'd1,
        ST_COLLECT = 3'd2,
        ST_HOLD    = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    localparam int WORD_W_DEF    = 32;
    localparam int WARMUP_DEF    = 16;
    localparam int REP_LIMIT_DEF = 32;

    // Width able to hold a counter's terminal value without wrapping.
    function automatic int cnt_w(input int terminal);
        return $clog2(terminal) + 1;
    endfunction

endpackage

// File: rtl/vn_debiaser.sv
// Von Neumann pair debiaser: 10 -> 1, 01 -> 0, 00/11 dropped.
// bit_valid is combinational on the second raw bit of an unequal pair.
module vn_debiaser
    import trng_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic sample_en,
    input  logic clear,
    output logic bit_out,
    output logic bit_valid
);

    logic pair_phase;
    logic bit_a;

    assign bit_out   = bit_a;
    assign bit_valid = sample_en && pair_phase && (raw != bit_a);

    // Capture the first bit of each pair and flip the pair phase per sample.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pair_phase <= 1'b0;
            bit_a      <= 1'b0;
        end else if (sample_en) begin
            if (!pair_phase) begin
                bit_a <= raw;
            end
            pair_phase <= !pair_phase;
        end
    end

endmodule

// File: rtl/ro_entropy_collector.sv
// Ring-oscillator entropy collector: XOR combine, repetition health test,
// von Neumann debiasing and word packing behind a valid/ready handshake.
module ro_entropy_collector
    import trng_pkg::*;
#(
    parameter int NUM_RO    = 4,
    parameter int WORD_W    = WORD_W_DEF,
    parameter int WARMUP    = WARMUP_DEF,
    parameter int REP_LIMIT = REP_LIMIT_DEF
) (
    input  logic              ro_clk,
    input  logic              ro_rst_n,
    input  logic              en,
    input  logic [NUM_RO-1:0] ro_bits,
    output logic [WORD_W-1:0] rnd_data,
    output logic              rnd_valid,
    input  logic              rnd_ready,
    output logic              health_fail,
    output logic              busy
);

    localparam int WC_W = cnt_w(WARMUP);
    localparam int BC_W = cnt_w(WORD_W);
    localparam int RC_W = cnt_w(REP_LIMIT);

    localparam logic [WC_W-1:0] WARM_LAST = WC_W'(WARMUP - 1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WORD_W - 1);
    localparam logic [RC_W-1:0] REP_TRIP  = RC_W'(REP_LIMIT);
    localparam logic [RC_W-1:0] REP_ONE   = RC_W'(1);

    state_t          state;
    logic [WC_W-1:0] warm_cnt;
    logic [BC_W-1:0] bit_cnt;
    logic [RC_W-1:0] rep_cnt;
    logic [RC_W-1:0] rep_next;
    logic            last_raw;
    logic            raw;
    logic            collecting;
    logic            vn_clear;
    logic            rep_same;
    logic            trip;
    logic            handshake;
    logic            bit_out;
    logic            bit_valid;

    assign raw        = ^ro_bits;
    assign collecting = (state == ST_COLLECT) && en;
    assign vn_clear   = !collecting;
    assign rep_same   = (rep_cnt != '0) && (raw == last_raw);
    assign rep_next   = rep_same ? rep_cnt + 1'b1 : REP_ONE;
    assign trip       = collecting && (rep_next == REP_TRIP);
    assign handshake  = (state == ST_HOLD) && rnd_valid && rnd_ready;
    assign busy       = (state == ST_WARMUP) || (state == ST_COLLECT);

    vn_debiaser u_vn (
        .clk       (ro_clk),
        .rst_n     (ro_rst_n),
        .raw       (raw),
        .sample_en (collecting),
        .clear     (vn_clear),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

    // Run-length of identical raw bits; a zero count means "seed on next bit".
    always_ff @(posedge ro_clk) begin
        if (!ro_rst_n) begin
            rep_cnt  <= '0;
            last_raw <= 1'b0;
        end else if (collecting) begin
            rep_cnt  <= rep_next;
            last_raw <= raw;
        end else begin
            rep_cnt  <= '0;
        end
    end

    // Collector FSM with warm-up counter, word shift register and handshake.
    always_ff @(posedge ro_clk) begin
        if (!ro_rst_n) begin
            state       <= ST_IDLE;
            warm_cnt    <= '0;
            bit_cnt     <= '0;
            rnd_data    <= '0;
            rnd_valid   <= 1'b0;
            health_fail <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (en) begin
                        state    <= ST_WARMUP;
                        warm_cnt <= '0;
                    end
                end
                ST_WARMUP: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (warm_cnt == WARM_LAST) begin
                        state <= ST_COLLECT;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (!en) begin
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        rnd_data <= '0;
                    end else if (trip) begin
                        state       <= ST_FAIL;
                        health_fail <= 1'b1;
                        rnd_valid   <= 1'b0;
                        bit_cnt     <= '0;
                        rnd_data    <= '0;
                    end else if (bit_valid) begin
                        rnd_data <= {rnd_data[WORD_W-2:0], bit_out};
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_LAST) begin
                            state     <= ST_HOLD;
                            rnd_valid <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        rnd_valid <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= en ? ST_COLLECT : ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    state <= ST_FAIL;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ro_entropy_collector.sv
// Randomized bench for ro_entropy_collector against a queue-based model.
// The model tracks raw bits per collection and packs debiased pairs itself.
module tb_ro_entropy_collector;

    localparam int NRO  = 4;
    localparam int W    = 32;
    localparam int WARM = 16;
    localparam int REP  = 32;
    localparam int LAT  = WARM + 2 * W + 1;

    localparam int M_IDLE = 0;
    localparam int M_WARM = 1;
    localparam int M_COLL = 2;
    localparam int M_HOLD = 3;
    localparam int M_FAIL = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [NRO-1:0] ro_in = '0;
    logic           rdy = 1'b0;
    logic [W-1:0]   rnd_data;
    logic           rnd_valid;
    logic           health_fail;
    logic           busy;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    int           m_st = M_IDLE;
    int           m_wc = 0;
    int           m_run = 0;
    logic         m_last = 1'b0;
    logic         m_valid = 1'b0;
    logic         m_hf = 1'b0;
    logic [W-1:0] m_word = '0;
    logic         rawq[$];
    logic         bits[$];

    ro_entropy_collector #(
        .NUM_RO    (NRO),
        .WORD_W    (W),
        .WARMUP    (WARM),
        .REP_LIMIT (REP)
    ) dut (
        .ro_clk      (clk),
        .ro_rst_n    (rst_n),
        .en          (en),
        .ro_bits     (ro_in),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .rnd_ready   (rdy),
        .health_fail (health_fail),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)",
                     tag, got, exp, ncyc);
        end
    endtask

    function automatic logic [NRO-1:0] par(input logic b);
        logic [NRO-1:0] r;
        r = NRO'($urandom);
        r[0] = ^r[NRO-1:1] ^ b;
        return r;
    endfunction

    function automatic void begin_collect();
        rawq.delete();
        bits.delete();
        m_run = 0;
    endfunction

    // Spec-level reaction of the collector to one rising edge.
    function automatic void model_edge();
        logic raw;
        raw = ^ro_in;
        if (!rst_n) begin
            m_st = M_IDLE;
            m_valid = 1'b0;
            m_hf = 1'b0;
            m_word = '0;
            begin_collect();
            return;
        end
        case (m_st)
            M_IDLE: if (en) begin
                m_st = M_WARM;
                m_wc = 0;
            end
            M_WARM: begin
                if (!en) m_st = M_IDLE;
                else if (m_wc == WARM - 1) begin
                    m_st = M_COLL;
                    begin_collect();
                end else m_wc++;
            end
            M_COLL: begin
                if (!en) m_st = M_IDLE;
                else begin
                    m_run = (rawq.size() > 0 && raw == m_last) ? m_run + 1 : 1;
                    m_last = raw;
                    rawq.push_back(raw);
                    if (m_run == REP) begin
                        m_st = M_FAIL;
                        m_hf = 1'b1;
                        m_valid = 1'b0;
                    end else if (rawq.size() % 2 == 0 &&
                                 rawq[$] != rawq[$-1]) begin
                        bits.push_back(rawq[$-1]);
                        if (bits.size() == W) begin
                            m_word = '0;
                            foreach (bits[i]) m_word = {m_word[W-2:0], bits[i]};
                            m_valid = 1'b1;
                            m_st = M_HOLD;
                        end
                    end
                end
            end
            M_HOLD: if (rdy) begin
                m_valid = 1'b0;
                m_st = en ? M_COLL : M_IDLE;
                begin_collect();
            end
            default: ;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        ncyc++;
        chk("valid", 32'(rnd_valid), 32'(m_valid));
        chk("hfail", 32'(health_fail), 32'(m_hf));
        chk("busy", 32'(busy), 32'(m_st == M_WARM || m_st == M_COLL));
        if (m_valid) chk("data", rnd_data, m_word);
    endtask

    // Idle through non-collecting cycles, then present one raw sample.
    task automatic put_ro(input logic [NRO-1:0] v);
        int g;
        g = 0;
        while (m_st != M_COLL && g < 100) begin
            ro_in = NRO'($urandom);
            step();
            g++;
        end
        if (m_st != M_COLL) chk("wait_collect", m_st, M_COLL);
        ro_in = v;
        step();
    endtask

    task automatic handshake();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
    endtask

    initial begin
        int t0;
        rst_n = 1'b0;
        step();
        step();
        chk("rst_valid", 32'(rnd_valid), 0);
        chk("rst_data", rnd_data, 0);
        chk("rst_hfail", 32'(health_fail), 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        step();

        en = 1'b1;
        t0 = ncyc;
        for (int i = 0; i < 16; i++) begin
            put_ro(4'b0001);
            put_ro(4'b0000);
        end
        for (int i = 0; i < 16; i++) begin
            put_ro(4'b0000);
            put_ro(4'b0001);
        end
        chk("t1_lat", ncyc - t0, LAT);
        chk("t1_data", rnd_data, 32'hFFFF0000);
        chk("t1_busy", 32'(busy), 0);

        for (int i = 0; i < 10; i++) begin
            ro_in = NRO'($urandom);
            step();
        end
        chk("t2_hold_data", rnd_data, 32'hFFFF0000);
        chk("t2_hold_valid", 32'(rnd_valid), 1);
        handshake();
        chk("t2_after_hs", 32'(rnd_valid), 0);
        chk("t2_collect", 32'(busy), 1);
        for (int i = 0; i < 32; i++) begin
            put_ro(par(1'b0));
            put_ro(par(1'b1));
        end
        chk("t2_data", rnd_data, 32'h00000000);
        chk("t2_valid", 32'(rnd_valid), 1);
        handshake();

        for (int i = 0; i < 198; i++) put_ro(par(i % 4 >= 2));
        chk("t3_novalid", 32'(rnd_valid), 0);
        chk("t3_nofail", 32'(health_fail), 0);
        for (int i = 1; i <= 32; i++) begin
            put_ro(par(1'b1));
            if (i == 31) chk("t3_pre_trip", 32'(health_fail), 0);
        end
        chk("t3_trip", 32'(health_fail), 1);
        for (int i = 0; i < 12; i++) begin
            en = i[0];
            ro_in = NRO'($urandom);
            step();
        end
        chk("t3_sticky", 32'(health_fail), 1);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t4_cleared", 32'(health_fail), 0);
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            put_ro(par(1'b1));
            put_ro(par(1'b0));
        end
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ro_in = NRO'($urandom);
            step();
        end
        chk("t4_idle", 32'(busy), 0);
        en = 1'b1;
        t0 = ncyc;
        for (int i = 0; i < 32; i++) begin
            put_ro(par(1'b1));
            put_ro(par(1'b0));
        end
        chk("t4_lat", ncyc - t0, LAT);
        chk("t4_data", rnd_data, 32'hFFFFFFFF);
        handshake();

        for (int i = 0; i < 32; i++) begin
            put_ro(4'b1011);
            put_ro(4'b0011);
        end
        chk("t5_data", rnd_data, 32'hFFFFFFFF);
        chk("t5_valid", 32'(rnd_valid), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t5_rst_valid", 32'(rnd_valid), 0);
        chk("t5_rst_data", rnd_data, 0);
        chk("t5_rst_busy", 32'(busy), 0);
        en = 1'b0;
        step();
        chk("t5_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
